// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline constants for fetch, decode and hazard logic
package cpu_pkg;
    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush, hold and valid bit
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic [INST_W-1:0] load_inst,
    input  logic [31:0]       load_pc4,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       pc4,
    output logic              valid
);

    // Flush beats hold so a taken branch never leaves a stale instruction behind.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inst  <= NOP_INST;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (!hold) begin
            inst  <= load_inst;
            pc4   <= load_pc4;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC register, next-PC mux, fetch counter
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0]       RESET_PC = RESET_PC_DEFAULT,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic [INST_W-1:0] id_inst,
    output logic [31:0]       id_pc4,
    output logic              id_valid,
    output logic [31:0]       fetch_count
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] count_q;
    logic        advance;

    assign pc_plus4 = pc_q + PC_STEP;
    assign advance  = !redirect && !stall;

    // Targets are word aligned; the low address bits of a redirect are dropped.
    always_comb begin
        pc_next = pc_q;
        if (redirect)
            pc_next = redirect_pc & ~(PC_STEP - 32'd1);
        else if (!stall)
            pc_next = pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= 32'h0;
        end else begin
            pc_q <= pc_next;
            if (advance)
                count_q <= count_q + 32'd1;
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .hold      (stall),
        .load_inst (rom_inst),
        .load_pc4  (pc_plus4),
        .inst      (id_inst),
        .pc4       (id_pc4),
        .valid     (id_valid)
    );

    assign rom_addr    = pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed table-driven bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs [22];

    always #5 clk = ~clk;

    assign rom_inst = mem[rom_addr[7:2]];

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_addr    (rom_addr),
        .rom_inst    (rom_inst),
        .id_inst     (id_inst),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .fetch_count (fetch_count)
    );

    function automatic logic [31:0] rom_at(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic j, input logic [31:0] rpc,
                                input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] pc4,
                                input logic v, input logic [31:0] cnt);
        vec_t t;
        t.rst = r; t.stall = s; t.redirect = j; t.rpc = rpc;
        t.pc = pc; t.inst = inst; t.pc4 = pc4; t.valid = v; t.cnt = cnt;
        return t;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                             input logic [31:0] pc4, input logic v, input logic [31:0] cnt);
        check32({tag, " rom_addr"}, rom_addr, pc);
        check32({tag, " id_inst"}, id_inst, inst);
        check32({tag, " id_pc4"}, id_pc4, pc4);
        check32({tag, " id_valid"}, {31'b0, id_valid}, {31'b0, v});
        check32({tag, " fetch_count"}, fetch_count, cnt);
    endtask

    task automatic step(input logic r, input logic s, input logic j, input logic [31:0] rpc);
        rst = r; stall = s; redirect = j; redirect_pc = rpc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'h1400_0401;
        mem[1] = 32'h1400_0802;
        mem[2] = 32'h1400_1003;

        //             rst stall redir rpc            pc             inst                    pc4            v     cnt
        vecs[0]  = mk(1, 0, 0, 32'h0,          32'h0,         32'h0,                 32'h0,         0, 32'd0);
        vecs[1]  = mk(0, 0, 0, 32'h0,          32'h4,         32'h1400_0401,         32'h4,         1, 32'd1);
        vecs[2]  = mk(0, 0, 0, 32'h0,          32'h8,         32'h1400_0802,         32'h8,         1, 32'd2);
        vecs[3]  = mk(0, 0, 0, 32'h0,          32'hC,         32'h1400_1003,         32'hC,         1, 32'd3);
        vecs[4]  = mk(0, 0, 0, 32'h0,          32'h10,        rom_at(32'hC),         32'h10,        1, 32'd4);
        vecs[5]  = mk(0, 1, 0, 32'h0,          32'h10,        rom_at(32'hC),         32'h10,        1, 32'd4);
        vecs[6]  = mk(0, 1, 0, 32'h0,          32'h10,        rom_at(32'hC),         32'h10,        1, 32'd4);
        vecs[7]  = mk(0, 0, 0, 32'h0,          32'h14,        rom_at(32'h10),        32'h14,        1, 32'd5);
        vecs[8]  = mk(0, 0, 0, 32'h0,          32'h18,        rom_at(32'h14),        32'h18,        1, 32'd6);
        vecs[9]  = mk(0, 0, 1, 32'h23,         32'h20,        32'h0,                 32'h0,         0, 32'd6);
        vecs[10] = mk(0, 0, 0, 32'h0,          32'h24,        rom_at(32'h20),        32'h24,        1, 32'd7);
        vecs[11] = mk(0, 1, 1, 32'h40,         32'h40,        32'h0,                 32'h0,         0, 32'd7);
        vecs[12] = mk(0, 1, 0, 32'h0,          32'h40,        32'h0,                 32'h0,         0, 32'd7);
        vecs[13] = mk(0, 0, 0, 32'h0,          32'h44,        rom_at(32'h40),        32'h44,        1, 32'd8);
        vecs[14] = mk(0, 0, 1, 32'h30,         32'h30,        32'h0,                 32'h0,         0, 32'd8);
        vecs[15] = mk(0, 0, 0, 32'h0,          32'h34,        rom_at(32'h30),        32'h34,        1, 32'd9);
        vecs[16] = mk(0, 1, 0, 32'h0,          32'h34,        rom_at(32'h30),        32'h34,        1, 32'd9);
        vecs[17] = mk(1, 1, 0, 32'h0,          32'h0,         32'h0,                 32'h0,         0, 32'd0);
        vecs[18] = mk(0, 1, 0, 32'h0,          32'h0,         32'h0,                 32'h0,         0, 32'd0);
        vecs[19] = mk(0, 0, 0, 32'h0,          32'h4,         32'h1400_0401,         32'h4,         1, 32'd1);
        vecs[20] = mk(0, 0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFC, 32'h0,                 32'h0,         0, 32'd1);
        vecs[21] = mk(0, 0, 0, 32'h0,          32'h0,         rom_at(32'hFFFF_FFFC), 32'h0,         1, 32'd2);

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].inst, vecs[i].pc4, vecs[i].valid, vecs[i].cnt);
        end

        // Counter wrap: preload the top value, then one normal fetch.
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        check32("preload fetch_count", fetch_count, 32'hFFFF_FFFF);
        step(0, 0, 0, 32'h0);
        check_all("count_wrap", 32'h4, 32'h1400_0401, 32'h4, 1'b1, 32'h0);

        // Reset held across several edges keeps everything at reset values.
        step(1, 0, 0, 32'h0);
        check_all("rst_hold1", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        step(1, 0, 1, 32'h80);
        check_all("rst_hold2", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        step(0, 0, 0, 32'h0);
        check_all("rst_release", 32'h4, 32'h1400_0401, 32'h4, 1'b1, 32'h1);
        step(0, 0, 0, 32'h0);
        check_all("after_release", 32'h8, 32'h1400_0802, 32'h8, 1'b1, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
